// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the control unit and the sequential ALU
interface alu_seq_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       control;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;
  logic             busy;
  logic             done;
  modport master (
    output start, control, op1, op2,
    input  result, zero, overflow, hi, lo, div_by_zero, busy, done
  );
  modport slave (
    input  start, control, op1, op2,
    output result, zero, overflow, hi, lo, div_by_zero, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle ops and iterative unsigned multiply/divide into HI/LO
module alu_seq #(
  parameter int WIDTH      = 32,
  parameter bit MUL_ENABLE = 1'b1
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);
  localparam int SW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t             state, state_next;
  logic [2*WIDTH-1:0] p, mul_next, div_next, p_next;
  logic [WIDTH-1:0]   mc, alu_res, sum, diff, rem_sub;
  logic [WIDTH:0]     mul_add, div_t;
  logic [SW-1:0]      cnt;
  logic               alu_ovf, is_mul, is_div, div_zero, div_ge;
  assign is_mul   = MUL_ENABLE && bus.control == 4'd9;
  assign is_div   = MUL_ENABLE && bus.control == 4'd10;
  assign div_zero = is_div && bus.op2 == '0;
  assign sum      = bus.op1 + bus.op2;
  assign diff     = bus.op1 - bus.op2;
  assign bus.busy = state != IDLE;
  assign bus.zero = bus.result == '0;
  // p holds {partial product, multiplier} for MUL and {remainder, dividend} for DIV
  assign mul_add  = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mc} : '0);
  assign mul_next = {mul_add, p[WIDTH-1:1]};
  assign div_t    = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
  assign div_ge   = div_t >= {1'b0, mc};
  assign rem_sub  = div_t[WIDTH-1:0] - mc;
  assign div_next = {div_ge ? rem_sub : div_t[WIDTH-1:0], p[WIDTH-2:0], div_ge};
  assign p_next   = state == DIV ? div_next : mul_next;
  // Single-cycle result and signed overflow of ADD/SUB
  always_comb begin
    alu_res = bus.op1;
    alu_ovf = 1'b0;
    case (bus.control)
      4'd0: begin
        alu_res = sum;
        alu_ovf = (bus.op1[WIDTH-1] == bus.op2[WIDTH-1]) && (sum[WIDTH-1] != bus.op1[WIDTH-1]);
      end
      4'd1: begin
        alu_res = diff;
        alu_ovf = (bus.op1[WIDTH-1] != bus.op2[WIDTH-1]) && (diff[WIDTH-1] != bus.op1[WIDTH-1]);
      end
      4'd2: alu_res = bus.op1 << bus.op2[SW-1:0];
      4'd3: alu_res = bus.op1 & bus.op2;
      4'd4: alu_res = bus.op1 | bus.op2;
      4'd5: alu_res = bus.op1 ^ bus.op2;
      4'd6: alu_res = ~(bus.op1 | bus.op2);
      4'd8: alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.op1) < $signed(bus.op2)};
      default: alu_res = bus.op1;
    endcase
  end
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  // Next state: enter MUL/DIV on accept, return to IDLE after the last iteration
  always_comb begin
    state_next = state;
    if (state == IDLE)
      state_next = !bus.start ? IDLE : is_mul ? MUL : (is_div && !div_zero) ? DIV : IDLE;
    else if (cnt == '0)
      state_next = IDLE;
  end
  // Datapath: accept in IDLE, iterate in MUL/DIV, publish results with a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.result      <= '0;
      bus.overflow    <= 1'b0;
      bus.hi          <= '0;
      bus.lo          <= '0;
      bus.div_by_zero <= 1'b0;
      bus.done        <= 1'b0;
      p               <= '0;
      mc              <= '0;
      cnt             <= '0;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          bus.overflow    <= 1'b0;
          bus.div_by_zero <= 1'b0;
          if (div_zero) begin
            bus.lo          <= '1;
            bus.hi          <= bus.op1;
            bus.result      <= '1;
            bus.div_by_zero <= 1'b1;
            bus.done        <= 1'b1;
          end else if (is_mul || is_div) begin
            p   <= {{WIDTH{1'b0}}, bus.op1};
            mc  <= bus.op2;
            cnt <= SW'(WIDTH - 1);
          end else begin
            bus.result   <= alu_res;
            bus.overflow <= alu_ovf;
            bus.done     <= 1'b1;
          end
        end
      end else begin
        p   <= p_next;
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          bus.hi     <= p_next[2*WIDTH-1:WIDTH];
          bus.lo     <= p_next[WIDTH-1:0];
          bus.result <= p_next[WIDTH-1:0];
          bus.done   <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table vectors, directed multi-cycle sequences and random ops against a reference model
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  alu_seq_if #(.WIDTH(32)) bus();
  alu_seq #(.WIDTH(32), .MUL_ENABLE(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  typedef struct {
    logic [31:0] r, hi, lo;
    logic o, d;
    int lat;
  } exp_t;
  typedef struct {
    logic [3:0] c;
    logic [31:0] a, b, r;
    logic o;
  } vec_t;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] hi0, input logic [31:0] lo0);
    exp_t e;
    longint s;
    logic [63:0] pr;
    e.hi = hi0; e.lo = lo0; e.o = 1'b0; e.d = 1'b0; e.lat = 1;
    case (c)
      4'd0: begin e.r = a + b; s = longint'($signed(a)) + longint'($signed(b)); e.o = s != longint'($signed(e.r)); end
      4'd1: begin e.r = a - b; s = longint'($signed(a)) - longint'($signed(b)); e.o = s != longint'($signed(e.r)); end
      4'd2: e.r = a << b[4:0];
      4'd3: e.r = a & b;
      4'd4: e.r = a | b;
      4'd5: e.r = a ^ b;
      4'd6: e.r = ~(a | b);
      4'd8: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: begin
        pr = {32'b0, a} * {32'b0, b};
        e.hi = pr[63:32]; e.lo = pr[31:0]; e.r = e.lo; e.lat = 33;
      end
      4'd10: begin
        if (b == 0) begin e.lo = '1; e.hi = a; e.r = '1; e.d = 1'b1; end
        else begin e.lo = a / b; e.hi = a % b; e.r = e.lo; e.lat = 33; end
      end
      default: e.r = a;
    endcase
    return e;
  endfunction
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bc);
    bus.start = 1'b1; bus.control = c; bus.op1 = a; bus.op2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1; bc = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask
  task automatic check_op(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int lat, bc;
    e = model(c, a, b, m_hi, m_lo);
    run_op(c, a, b, lat, bc);
    chk({tag, ".lat"}, lat, e.lat);
    chk({tag, ".busy_cycles"}, bc, e.lat - 1);
    chk({tag, ".busy_at_done"}, bus.busy, 0);
    chk({tag, ".result"}, bus.result, e.r);
    chk({tag, ".zero"}, bus.zero, e.r == 0);
    chk({tag, ".overflow"}, bus.overflow, e.o);
    chk({tag, ".hi"}, bus.hi, e.hi);
    chk({tag, ".lo"}, bus.lo, e.lo);
    chk({tag, ".dbz"}, bus.div_by_zero, e.d);
    m_hi = e.hi; m_lo = e.lo;
  endtask
  initial begin
    vec_t vt[13];
    int lat, bc, nd;
    logic [31:0] rb;
    bus.start = 1'b0; bus.control = '0; bus.op1 = '0; bus.op2 = '0;
    vt[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1};
    vt[1]  = '{4'd1,  32'd5,        32'd5,        32'd0,        1'b0};
    vt[2]  = '{4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1};
    vt[3]  = '{4'd2,  32'h00000001, 32'd35,       32'h00000008, 1'b0};
    vt[4]  = '{4'd3,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
    vt[5]  = '{4'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0};
    vt[6]  = '{4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0};
    vt[7]  = '{4'd6,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vt[8]  = '{4'd7,  32'h12345678, 32'h0000FFFF, 32'h12345678, 1'b0};
    vt[9]  = '{4'd8,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    vt[10] = '{4'd8,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vt[11] = '{4'd13, 32'hCAFEBABE, 32'h00000003, 32'hCAFEBABE, 1'b0};
    vt[12] = '{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    #12;
    chk("reset.result", bus.result, 0);
    chk("reset.hi", bus.hi, 0);
    chk("reset.lo", bus.lo, 0);
    chk("reset.zero", bus.zero, 1);
    chk("reset.busy", bus.busy, 0);
    chk("reset.done", bus.done, 0);
    chk("reset.overflow", bus.overflow, 0);
    chk("reset.dbz", bus.div_by_zero, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    foreach (vt[i]) begin
      run_op(vt[i].c, vt[i].a, vt[i].b, lat, bc);
      chk($sformatf("vec%0d.lat", i), lat, 1);
      chk($sformatf("vec%0d.result", i), bus.result, vt[i].r);
      chk($sformatf("vec%0d.overflow", i), bus.overflow, vt[i].o);
      chk($sformatf("vec%0d.zero", i), bus.zero, vt[i].r == 0);
      chk($sformatf("vec%0d.hi", i), bus.hi, 0);
    end
    run_op(4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
    chk("mul_max.lat", lat, 33);
    chk("mul_max.busy_cycles", bc, 32);
    chk("mul_max.hi", bus.hi, 32'hFFFFFFFE);
    chk("mul_max.lo", bus.lo, 32'h00000001);
    chk("mul_max.result", bus.result, 32'h00000001);
    @(posedge clk); #1;
    chk("mul_max.done_pulse", bus.done, 0);
    run_op(4'd10, 32'd100, 32'd7, lat, bc);
    chk("div_100_7.lat", lat, 33);
    chk("div_100_7.lo", bus.lo, 14);
    chk("div_100_7.hi", bus.hi, 2);
    chk("div_100_7.dbz", bus.div_by_zero, 0);
    run_op(4'd10, 32'h1234, 32'h0, lat, bc);
    chk("div0.lat", lat, 1);
    chk("div0.busy_cycles", bc, 0);
    chk("div0.lo", bus.lo, 32'hFFFFFFFF);
    chk("div0.hi", bus.hi, 32'h1234);
    chk("div0.dbz", bus.div_by_zero, 1);
    run_op(4'd0, 32'd1, 32'd1, lat, bc);
    chk("dbz_cleared", bus.div_by_zero, 0);
    chk("single_keeps_hi", bus.hi, 32'h1234);
    bus.start = 1'b1; bus.control = 4'd9; bus.op1 = 32'd3; bus.op2 = 32'd4;
    @(posedge clk); #1;
    bus.control = 4'd0; bus.op1 = 32'd100; bus.op2 = 32'd200;
    nd = 0; lat = 1;
    while (nd == 0 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) begin nd++; bus.start = 1'b0; end
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) nd++;
    end
    chk("mul_busy_start.lat", lat, 33);
    chk("mul_busy_start.dones", nd, 1);
    chk("mul_busy_start.lo", bus.lo, 12);
    chk("mul_busy_start.hi", bus.hi, 0);
    chk("mul_busy_start.result", bus.result, 12);
    bus.start = 1'b1; bus.control = 4'd0; bus.op1 = 32'd1; bus.op2 = 32'd2;
    @(posedge clk); #1;
    chk("b2b0.done", bus.done, 1);
    chk("b2b0.result", bus.result, 3);
    bus.control = 4'd1; bus.op1 = 32'd10; bus.op2 = 32'd3;
    @(posedge clk); #1;
    chk("b2b1.done", bus.done, 1);
    chk("b2b1.result", bus.result, 7);
    bus.control = 4'd5; bus.op1 = 32'd5; bus.op2 = 32'd3;
    @(posedge clk); #1;
    chk("b2b2.done", bus.done, 1);
    chk("b2b2.result", bus.result, 6);
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("b2b.idle_done", bus.done, 0);
    m_hi = 32'h0; m_lo = 32'd12;
    check_op("mul_setup", 4'd9, 32'hDEADBEEF, 32'h0000BEEF);
    bus.start = 1'b1; bus.control = 4'd9; bus.op1 = 32'd12345; bus.op2 = 32'd6789;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort.busy", bus.busy, 0);
    chk("abort.hi", bus.hi, 0);
    chk("abort.lo", bus.lo, 0);
    chk("abort.result", bus.result, 0);
    chk("abort.zero", bus.zero, 1);
    chk("abort.done", bus.done, 0);
    m_hi = '0; m_lo = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_op("slt_after_reset", 4'd8, 32'hFFFFFFFF, 32'd1);
    chk("slt_after_reset.one", bus.result, 1);
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      check_op($sformatf("rnd%0d", k), 4'($urandom_range(0, 15)), $urandom, rb);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
